wb_arbiter: RTL

- Writeback arbiter between two execution units (EU0 = ALU, EU1 = load/store) and the single register-file write port.
- Each EU hands off results through a valid/ready handshake into a one-entry holding slot per EU.
- A round-robin arbiter grants one slot per cycle into a registered write stage, which drives the register-file write and the matching free index to the pending register table.
- Resolves the single-write-port case: the table needs only one free port driven per cycle.

---
 rtl/wb_arbiter_if.sv | 30 +++
 rtl/wb_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback bundle: two execution-unit result handshakes in, one register-file write port out.
// Handshake: a result moves on a rising edge where valid && ready; valid never waits on ready, ready never looks at valid.
interface wb_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int RN_W   = 7
);
    logic              eu0_valid;
    logic              eu0_ready;
    logic [RN_W-1:0]   eu0_rn;
    logic [DATA_W-1:0] eu0_data;
    logic              eu1_valid;
    logic              eu1_ready;
    logic [RN_W-1:0]   eu1_rn;
    logic [DATA_W-1:0] eu1_data;
    logic              rf_we;
    logic [RN_W-1:0]   rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [RN_W-1:0]   free_rn;
    logic              oob_err;

    modport master (
        output eu0_valid, eu0_rn, eu0_data, eu1_valid, eu1_rn, eu1_data,
        input  eu0_ready, eu1_ready, rf_we, rf_waddr, rf_wdata, free_rn, oob_err
    );

    modport slave (
        input  eu0_valid, eu0_rn, eu0_data, eu1_valid, eu1_rn, eu1_data,
        output eu0_ready, eu1_ready, rf_we, rf_waddr, rf_wdata, free_rn, oob_err
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding slot per EU, round-robin grant into a registered
// register-file write stage that also returns the freed index to the pending table.
module wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int RN_W   = 7,
    parameter int NREGS  = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);
    localparam logic [RN_W:0] NREGS_L = (RN_W+1)'(NREGS);

    logic              slot0_valid_q, slot0_valid_d;
    logic [RN_W-1:0]   slot0_rn_q, slot0_rn_d;
    logic [DATA_W-1:0] slot0_data_q, slot0_data_d;
    logic              slot1_valid_q, slot1_valid_d;
    logic [RN_W-1:0]   slot1_rn_q, slot1_rn_d;
    logic [DATA_W-1:0] slot1_data_q, slot1_data_d;
    // rr_q = 0 means EU0 wins when both slots are full
    logic              rr_q, rr_d;

    logic              rf_we_q, rf_we_d;
    logic [RN_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [RN_W-1:0]   free_rn_q, free_rn_d;
    logic              oob_err_q, oob_err_d;

    logic              grant0, grant1, ready0, ready1, hs0, hs1;
    logic [RN_W-1:0]   sel_rn;
    logic [DATA_W-1:0] sel_data;
    logic              in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_valid_q <= 1'b0;
            slot0_rn_q    <= '0;
            slot0_data_q  <= '0;
            slot1_valid_q <= 1'b0;
            slot1_rn_q    <= '0;
            slot1_data_q  <= '0;
            rr_q          <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            free_rn_q     <= '0;
            oob_err_q     <= 1'b0;
        end else begin
            slot0_valid_q <= slot0_valid_d;
            slot0_rn_q    <= slot0_rn_d;
            slot0_data_q  <= slot0_data_d;
            slot1_valid_q <= slot1_valid_d;
            slot1_rn_q    <= slot1_rn_d;
            slot1_data_q  <= slot1_data_d;
            rr_q          <= rr_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            free_rn_q     <= free_rn_d;
            oob_err_q     <= oob_err_d;
        end
    end

    // Grant and ready depend only on registered state, so ready never sees valid.
    always_comb begin
        grant0   = slot0_valid_q & (~slot1_valid_q | ~rr_q);
        grant1   = slot1_valid_q & (~slot0_valid_q |  rr_q);
        ready0   = ~slot0_valid_q | grant0;
        ready1   = ~slot1_valid_q | grant1;
        hs0      = bus.eu0_valid & ready0;
        hs1      = bus.eu1_valid & ready1;
        sel_rn   = grant1 ? slot1_rn_q   : slot0_rn_q;
        sel_data = grant1 ? slot1_data_q : slot0_data_q;
        in_range = {1'b0, sel_rn} < NREGS_L;
    end

    always_comb begin
        slot0_valid_d = slot0_valid_q & ~grant0;
        slot0_rn_d    = slot0_rn_q;
        slot0_data_d  = slot0_data_q;
        slot1_valid_d = slot1_valid_q & ~grant1;
        slot1_rn_d    = slot1_rn_q;
        slot1_data_d  = slot1_data_q;
        if (hs0) begin
            slot0_valid_d = 1'b1;
            slot0_rn_d    = bus.eu0_rn;
            slot0_data_d  = bus.eu0_data;
        end
        if (hs1) begin
            slot1_valid_d = 1'b1;
            slot1_rn_d    = bus.eu1_rn;
            slot1_data_d  = bus.eu1_data;
        end

        rr_d = rr_q;
        if (grant0)      rr_d = 1'b1;
        else if (grant1) rr_d = 1'b0;

        // Out-of-range results are consumed but never written; address/data hold.
        rf_we_d    = (grant0 | grant1) & in_range;
        oob_err_d  = (grant0 | grant1) & ~in_range;
        rf_waddr_d = rf_we_d ? sel_rn   : rf_waddr_q;
        rf_wdata_d = rf_we_d ? sel_data : rf_wdata_q;
        free_rn_d  = rf_we_d ? sel_rn   : '0;
    end

    assign bus.eu0_ready = ready0;
    assign bus.eu1_ready = ready1;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.free_rn   = free_rn_q;
    assign bus.oob_err   = oob_err_q;
endmodule
